// File: rtl/jt7759_pkg.sv
// Shared definitions for the JT7759 slave-mode host feeder.
package jt7759_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ARM,
    WR_WRITE,
    WR_HOLD
  } wr_st_t;

  localparam int WR_MAX_DEF = 31;

endpackage

// File: rtl/jt7759_feeder_fifo.sv
// 2x8 byte FIFO between ROM fetch and chip writes; zero-latency head, push/pop same cycle.
// Flush wins over push/pop; push while full and pop while empty are dropped.
module jt7759_feeder_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic       wp, rp;

  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign head  = mem[rd_ptr];
  assign wp    = push && !full;
  assign rp    = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= 8'd0;
      mem[1] <= 8'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wp) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (rp) rd_ptr <= ~rd_ptr;
      case ({wp, rp})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jt7759_feeder.sv
// Streams len ROM bytes to a JT7759 in slave mode, one cs/wrn write per drqn request.
// Write strobe held until the chip raises drqn; abandoned after WR_MAX cen ticks.
module jt7759_feeder
  import jt7759_pkg::*;
#(
  parameter int AW     = 17,
  parameter int WR_MAX = WR_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          tout,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  input  logic          drqn,
  output logic          cs,
  output logic          wrn,
  output logic [7:0]    dout
);

  localparam int TW = $clog2(WR_MAX + 1);

  wr_st_t        st;
  logic [AW-1:0] len_r, fetched, sent;
  logic [TW-1:0] tcnt;
  logic [7:0]    head;
  logic          full, empty, push, pop, flush, start_ok, abort_to;

  assign rom_cs   = busy && !full && (fetched != len_r);
  assign start_ok = start && !busy && !stop;
  assign abort_to = (st == WR_WRITE) && !drqn && cen && (tcnt == TW'(WR_MAX - 1));
  assign flush    = stop || abort_to;
  assign push     = rom_cs && rom_ok && !flush;
  assign pop      = (st == WR_WRITE) && drqn && !stop;

  jt7759_feeder_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rom_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= WR_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tout     <= 1'b0;
      rom_addr <= '0;
      len_r    <= '0;
      fetched  <= '0;
      sent     <= '0;
      tcnt     <= '0;
      cs       <= 1'b0;
      wrn      <= 1'b1;
      dout     <= 8'd0;
    end else begin
      done <= 1'b0;
      tout <= 1'b0;
      if (push) begin
        rom_addr <= rom_addr + AW'(1);
        fetched  <= fetched + AW'(1);
      end
      if (stop) begin
        st   <= WR_IDLE;
        busy <= 1'b0;
        cs   <= 1'b0;
        wrn  <= 1'b1;
      end else begin
        case (st)
          WR_IDLE: if (start_ok) begin
            rom_addr <= start_addr;
            len_r    <= len;
            fetched  <= '0;
            sent     <= '0;
            // An empty transfer completes without ever arming the write side
            if (len == '0) done <= 1'b1;
            else begin
              busy <= 1'b1;
              st   <= WR_ARM;
            end
          end
          WR_ARM: if (!drqn && !empty) begin
            st   <= WR_WRITE;
            cs   <= 1'b1;
            wrn  <= 1'b0;
            dout <= head;
            tcnt <= '0;
          end
          WR_WRITE: begin
            if (drqn) begin
              sent <= sent + AW'(1);
              st   <= WR_HOLD;
              cs   <= 1'b0;
              wrn  <= 1'b1;
            end else if (abort_to) begin
              tout <= 1'b1;
              busy <= 1'b0;
              st   <= WR_IDLE;
              cs   <= 1'b0;
              wrn  <= 1'b1;
            end else if (cen) begin
              tcnt <= tcnt + TW'(1);
            end
          end
          WR_HOLD: begin
            // One idle bus cycle between writes; a pending request is picked up in ARM
            if (sent == len_r) begin
              done <= 1'b1;
              busy <= 1'b0;
              st   <= WR_IDLE;
            end else begin
              st <= WR_ARM;
            end
          end
          default: st <= WR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt7759_feeder.sv
// Bench for jt7759_feeder: ROM and jt7759 slave models, scoreboard of written bytes.
module tb_jt7759_feeder;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic          cen = 1'b0, rom_ok = 1'b0, drqn = 1'b1;
  logic [AW-1:0] start_addr, len, rom_addr;
  logic [7:0]    rom_data = 8'd0, dout;
  logic          busy, done, tout, rom_cs, cs, wrn;

  jt7759_feeder #(.AW(AW), .WR_MAX(31)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .stop(stop),
    .start_addr(start_addr), .len(len), .busy(busy), .done(done), .tout(tout),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .drqn(drqn), .cs(cs), .wrn(wrn), .dout(dout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // model knobs (written by the stimulus) and observations (written by the models)
  int   rom_lat = 0, gap_max = 0, acc_lim = 1000000;
  bit   noise = 1'b0;
  logic [7:0] got[$];
  int   n_done = 0, n_tout = 0, n_viol = 0, n_cap = 0, n_wstart = 0;
  int   n_romcs = 0, n_cs = 0, wticks = 0, tout_ticks = 0;
  int   cnt = 0, gap = 0, cen_div = 0;
  logic cs_q = 1'b0;
  logic [AW-1:0] last_a = '0;

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    case (a)
      17'h100: return 8'h11;
      17'h101: return 8'h22;
      17'h102: return 8'h33;
      default: begin
        t = (a * AW'(7)) ^ (a >> 5);
        return t[7:0] ^ 8'h5A;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) n_done++;
    if (tout) begin n_tout++; tout_ticks = wticks; end
    if (cs !== ~wrn) n_viol++;
    if (rom_cs) n_romcs++;
    if (cs) n_cs++;
    if (cs && !cs_q) begin
      n_wstart++;
      if (n_wstart > n_cap) n_viol++;
    end
    cs_q = cs;
    if (!cs) wticks = 0;
    // jt7759 slave: accepts a strobed byte by raising drqn, requests again after a gap
    if (!drqn && cs && !wrn && got.size() < acc_lim) begin
      got.push_back(dout);
      drqn = 1'b1;
      gap  = $urandom_range(gap_max, 0);
    end else if (drqn) begin
      if (gap == 0) drqn = 1'b0;
      else gap--;
    end
    cen_div++;
    cen = (cen_div % 2) == 0;
    if (cs && cen) wticks++;
    // ROM: answers rom_lat cycles after the address settles; random rom_ok while idle
    if (rom_cs && rom_addr == last_a) cnt++;
    else begin cnt = 0; last_a = rom_addr; end
    rom_data = rom_byte(rom_addr);
    if (rom_cs) begin
      rom_ok = cnt >= rom_lat;
      if (rom_ok) n_cap++;
    end else begin
      rom_ok = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input logic [AW-1:0] a, input logic [AW-1:0] l, input string nm);
    int d0, t0, w0, r0, c0, cyc, nw;
    d0 = n_done; t0 = n_tout; w0 = got.size(); r0 = n_romcs; c0 = n_cs;
    start_addr = a; len = l; start = 1'b1;
    tick;
    start = 1'b0;
    if (l == '0) chk({nm, "_done1"}, 32'(done), 32'd1);
    cyc = 0;
    while (!(n_done > d0 && !busy) && cyc < 2000) begin tick; cyc++; end
    chk({nm, "_budget"}, 32'(cyc < 2000), 32'd1);
    chk({nm, "_ndone"}, 32'(n_done - d0), 32'd1);
    chk({nm, "_ntout"}, 32'(n_tout - t0), 32'd0);
    nw = got.size() - w0;
    chk({nm, "_nwr"}, 32'(nw), 32'(l));
    for (int i = 0; i < nw && i < int'(l); i++)
      chk($sformatf("%s_b%0d", nm, i), 32'(got[w0 + i]), 32'(rom_byte(a + AW'(i))));
    if (l == '0) begin
      chk({nm, "_romcs"}, 32'(n_romcs - r0), 32'd0);
      chk({nm, "_cs"}, 32'(n_cs - c0), 32'd0);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr, len;
    int            lat, gap;
    bit            noise;
    logic [AW-1:0] exp_end;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, w0, cyc;
    logic [AW-1:0] a, l;
    tbl[0] = '{17'h100,   17'd3, 0, 0, 1'b0, 17'h103};
    tbl[1] = '{17'h040,   17'd0, 0, 0, 1'b0, 17'h040};
    tbl[2] = '{17'h1FFFE, 17'd4, 1, 2, 1'b1, 17'h00002};
    tbl[3] = '{17'h200,   17'd5, 6, 0, 1'b0, 17'h205};
    tbl[4] = '{17'h010,   17'd1, 0, 3, 1'b1, 17'h011};
    tbl[5] = '{17'h300,   17'd8, 2, 0, 1'b1, 17'h308};

    rst = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0; len = '0;
    repeat (3) tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tout", 32'(tout), 32'd0);
    chk("rst_romcs", 32'(rom_cs), 32'd0);
    chk("rst_romaddr", 32'(rom_addr), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_wrn", 32'(wrn), 32'd1);
    chk("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    tick;

    for (int k = 0; k < 6; k++) begin
      rom_lat = tbl[k].lat; gap_max = tbl[k].gap; noise = tbl[k].noise;
      run_xfer(tbl[k].addr, tbl[k].len, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d_end", k), 32'(rom_addr), 32'(tbl[k].exp_end));
      if (k == 0) begin
        chk("t1_w0", 32'(got[0]), 32'h11);
        chk("t1_w1", 32'(got[1]), 32'h22);
        chk("t1_w2", 32'(got[2]), 32'h33);
        chk("t1_busy", 32'(busy), 32'd0);
      end
    end

    // write never accepted: timeout after 31 cen ticks in WRITE
    rom_lat = 0; gap_max = 0; noise = 1'b0; acc_lim = got.size();
    d0 = n_done; t0 = n_tout;
    start_addr = 17'h500; len = 17'd2; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (n_tout == t0 && cyc < 500) begin tick; cyc++; end
    chk("to_seen", 32'(n_tout - t0), 32'd1);
    chk("to_ticks", 32'(tout_ticks), 32'd31);
    chk("to_cs", 32'(cs), 32'd0);
    chk("to_wrn", 32'(wrn), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_nodone", 32'(n_done - d0), 32'd0);
    acc_lim = 1000000;
    run_xfer(17'h600, 17'd2, "after_to");

    // stop while byte 2 of 5 is strobed; a simultaneous start is ignored
    acc_lim = got.size() + 1;
    w0 = got.size();
    start_addr = 17'h700; len = 17'd5; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!(got.size() == acc_lim && cs) && cyc < 200) begin tick; cyc++; end
    chk("stop_reach", 32'(cyc < 200), 32'd1);
    chk("stop_b0", 32'(got[w0]), 32'(rom_byte(17'h700)));
    stop = 1'b1; start = 1'b1; start_addr = 17'h7A0; len = 17'd3;
    tick;
    stop = 1'b0; start = 1'b0;
    chk("stop_cs", 32'(cs), 32'd0);
    chk("stop_wrn", 32'(wrn), 32'd1);
    chk("stop_romcs", 32'(rom_cs), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    tick;
    chk("stop_nostart", 32'(busy), 32'd0);
    acc_lim = 1000000;
    run_xfer(17'h7A0, 17'd3, "restart");

    // async reset in the middle of a strobe
    acc_lim = got.size();
    w0 = got.size();
    start_addr = 17'h900; len = 17'd3; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!cs && cyc < 200) begin tick; cyc++; end
    rst = 1'b1;
    #1;
    chk("arst_cs", 32'(cs), 32'd0);
    chk("arst_wrn", 32'(wrn), 32'd1);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_romcs", 32'(rom_cs), 32'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("arst_nowrite", 32'(got.size() - w0), 32'd0);
    acc_lim = 1000000;
    run_xfer(17'h900, 17'd3, "post_rst");

    for (int r = 0; r < 20; r++) begin
      a = AW'($urandom);
      l = AW'($urandom_range(6, 0));
      rom_lat = $urandom_range(3, 0);
      gap_max = $urandom_range(3, 0);
      noise   = 1'($urandom_range(1, 0));
      run_xfer(a, l, $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_end", r), 32'(rom_addr), 32'(a + l));
    end

    chk("invariants", 32'(n_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
